// File: rtl/key_bar_pkg.sv
// Shared key indices, key count and the thermometer-bar decode used by key_bar_counter.
package key_bar_pkg;

  typedef enum logic [1:0] {
    KEY_UP   = 2'd0,
    KEY_DOWN = 2'd1,
    KEY_CLR  = 2'd2
  } key_idx_e;

  localparam int NUM_KEYS = 3;

  // Lamp n of the bar is lit while the count is above n.
  function automatic logic therm_decode(input logic [31:0] count, input logic [31:0] n);
    return (count > n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser, hold-time debouncer and registered press strobe.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 11111111
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_d, stable_q;
  logic             press_d, press_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Level must differ from the stable level for DEBOUNCE_CYCLES clocks before it is taken.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = {CNT_W{1'b0}};
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/key_bar_counter.sv
// Three debounced keys drive a saturating/wrapping up/down counter shown as a lamp bar.
// Optional buzzer beep per accepted press when BUZZER_BEEP_EN is defined.
module key_bar_counter
  import key_bar_pkg::*;
#(
  parameter int NUM_LAMPS       = 8,
  parameter int DEBOUNCE_CYCLES = 11111111,
  parameter bit WRAP            = 1'b0,
  parameter bit LAMP_ACTIVE_LOW = 1'b0,
  parameter int BEEP_CYCLES     = 2500000,
  localparam int CW             = $clog2(NUM_LAMPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_up_n,
  input  logic                 key_down_n,
  input  logic                 key_clr_n,
  output logic [CW-1:0]        count,
  output logic [NUM_LAMPS-1:0] lamps,
  output logic [NUM_KEYS-1:0]  press_pulse,
  output logic                 buzzer
);

  localparam logic [CW:0] MAX_EXT = (CW + 1)'(NUM_LAMPS);
  localparam logic [CW:0] ONE_EXT = (CW + 1)'(1);

  logic [NUM_KEYS-1:0] keys_n_s, stable_s, press_s;
  logic [NUM_KEYS-1:0] press_pulse_d, press_pulse_q;
  logic [CW-1:0]       count_d, count_q;
  logic [CW:0]         up_ext_s, dn_ext_s;

  assign keys_n_s = {key_clr_n, key_down_n, key_up_n};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .key_n (keys_n_s[k]),
      .stable(stable_s[k]),
      .press (press_s[k])
    );
  end

  // A strobe is only honoured while the key is still stably held.
  assign press_pulse_d = press_s & ~stable_s;

  // Counter next state: CLR wins, UP+DOWN cancel, then UP, then DOWN.
  always_comb begin
    up_ext_s = {1'b0, count_q} + ONE_EXT;
    dn_ext_s = {1'b0, count_q} - ONE_EXT;
    count_d  = count_q;
    if (press_pulse_q[KEY_CLR]) begin
      count_d = {CW{1'b0}};
    end else if (press_pulse_q[KEY_UP] && press_pulse_q[KEY_DOWN]) begin
      count_d = count_q;
    end else if (press_pulse_q[KEY_UP]) begin
      if (up_ext_s > MAX_EXT) count_d = WRAP ? {CW{1'b0}} : count_q;
      else                    count_d = up_ext_s[CW-1:0];
    end else if (press_pulse_q[KEY_DOWN]) begin
      if (dn_ext_s[CW]) count_d = WRAP ? MAX_EXT[CW-1:0] : count_q;
      else              count_d = dn_ext_s[CW-1:0];
    end else begin
      count_d = count_q;
    end
  end

  // Press strobes and count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse_q <= {NUM_KEYS{1'b0}};
      count_q       <= {CW{1'b0}};
    end else begin
      press_pulse_q <= press_pulse_d;
      count_q       <= count_d;
    end
  end

  for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_lamp
    assign lamps[i] = therm_decode(32'(count_q), 32'(i)) ^ LAMP_ACTIVE_LOW;
  end

  assign count       = count_q;
  assign press_pulse = press_pulse_q;

`ifdef BUZZER_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_d, beep_q;

  // Beep (re)starts together with any press strobe, then counts down.
  always_comb begin
    if (|press_pulse_d)      beep_d = BW'(BEEP_CYCLES);
    else if (beep_q != '0)   beep_d = beep_q - BW'(1);
    else                     beep_d = {BW{1'b0}};
  end

  // Beep length counter.
  always_ff @(posedge clk) begin
    if (rst) beep_q <= {BW{1'b0}};
    else     beep_q <= beep_d;
  end

  assign buzzer = (beep_q != {BW{1'b0}});
`else
  assign buzzer = 1'b0;
`endif

endmodule
